uart_tx: RTL and testbench

Byte-to-serial UART transmitter, the transmit-side counterpart to the team's UART receiver. It accepts 8-bit words over a valid/ready handshake and serialises each word as an idle-high asynchronous frame: start bit 0, eight data bits LSB first, optional even parity, and stop bit 1. A one-entry holding register lets the next byte queue during the current frame, so back-to-back frames go out with no idle gap. The block sits between the byte-producing logic and the board `Tx` pin.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_tx.sv | 83 ++++++++
 tb/tb_uart_tx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART line constants and transmitter state encoding (PARITY exists only with UART_TX_PARITY_EN)
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} uart_tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
`endif
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready byte handshake between a producer and the UART transmitter
interface uart_tx_if;
  import uart_pkg::*;
  logic [UART_DATA_BITS-1:0] data_in;
  logic data_valid;
  logic ready;
  modport master(output data_in, data_valid, input ready);
  modport slave(input data_in, data_valid, output ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter producing a one-cycle tick at terminal count
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  // count 0..CLKS_PER_BIT-1, restarting whenever the owner enters a new state
  always_ff @(posedge clk)
    if (rst || clear || tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with one-byte holding register; define UART_TX_PARITY_EN for even parity
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      Tx,
  output logic      busy
);
  localparam int IW = $clog2(UART_DATA_BITS);
  uart_tx_state_t state, state_n;
  logic [UART_DATA_BITS-1:0] shift, hold, load_byte;
  logic [IW-1:0] idx;
  logic hold_full, hold_full_n, tick, accept, direct, transfer, load, last_bit, tx_bit;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk,
    .rst,
    .clear(state_n != state),
    .tick
  );
  assign bus.ready = ~hold_full;
  assign accept = bus.data_valid & ~hold_full;
  assign last_bit = state == STOP & tick;
  assign direct = accept & (state == IDLE | last_bit);
  assign transfer = hold_full & last_bit;
  assign load = direct | transfer;
  assign load_byte = hold_full ? hold : bus.data_in;
  assign hold_full_n = accept & ~direct | hold_full & ~transfer;
  assign tx_bit = state == START ? UART_START_BIT : state == DATA ? shift[0] :
                  state == STOP ? UART_STOP_BIT : UART_IDLE_LEVEL;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: a load in IDLE or in the last STOP cycle starts a new frame with no gap
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   state_n = load ? START : IDLE;
      START:  state_n = tick ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:   state_n = tick && idx == IW'(UART_DATA_BITS - 1) ? PARITY : DATA;
      PARITY: state_n = tick ? STOP : PARITY;
`else
      DATA:   state_n = tick && idx == IW'(UART_DATA_BITS - 1) ? STOP : DATA;
`endif
      STOP:   state_n = tick ? (load ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
  end
  // control and registered outputs: Tx follows the current state one cycle later
  always_ff @(posedge clk)
    if (rst) begin
      hold_full <= 1'b0;
      busy <= 1'b0;
      idx <= '0;
      Tx <= UART_IDLE_LEVEL;
    end else begin
      hold_full <= hold_full_n;
      busy <= state_n != IDLE | hold_full_n;
      idx <= state == DATA ? idx + IW'(tick) : '0;
`ifdef UART_TX_PARITY_EN
      Tx <= state == PARITY ? par : tx_bit;
`else
      Tx <= tx_bit;
`endif
    end
  // data path: load the shifter, shift LSB first, and park a queued byte
  always_ff @(posedge clk) begin
    if (load) shift <= load_byte;
    else if (state == DATA && tick) shift <= shift >> 1;
    if (accept && !direct) hold <= bus.data_in;
`ifdef UART_TX_PARITY_EN
    if (load) par <= ^load_byte;
`endif
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (CLKS_PER_BIT 1 and 4) against a frame-timeline model
module tb_uart_tx;
  localparam int CPB0 = 1;
  localparam int CPB1 = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {int u; int a; int q; logic [7:0] b;} frame_t;
  typedef struct {int u; logic [7:0] b;} sent_t;
  typedef struct {logic dv; logic [7:0] d; logic tx; logic rdy; logic bsy;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dv = '0;
  logic [7:0] din [2];
  logic [1:0] tx_w, bsy_w, rdy_w, acc_last;
  frame_t fq[$];
  sent_t sq[$];
  int t = 0, errors = 0, checks = 0;
  int last_end[2];
  logic [1:0] dec_on = '0;
  int dec_c[2];
  logic [7:0] dec_b[2];
  uart_tx_if b0();
  uart_tx_if b1();
  assign b0.data_valid = dv[0];
  assign b0.data_in = din[0];
  assign b1.data_valid = dv[1];
  assign b1.data_in = din[1];
  assign rdy_w = {b1.ready, b0.ready};
  uart_tx #(.CLKS_PER_BIT(CPB0)) dut0 (.clk(clk), .rst(rst), .bus(b0), .Tx(tx_w[0]), .busy(bsy_w[0]));
  uart_tx #(.CLKS_PER_BIT(CPB1)) dut1 (.clk(clk), .rst(rst), .bus(b1), .Tx(tx_w[1]), .busy(bsy_w[1]));
  always #5 clk = ~clk;

  function automatic int cpb(int u);
    return u == 0 ? CPB0 : CPB1;
  endfunction
  // frame bit k: start, data LSB first, optional even parity, stop
  function automatic logic exp_bit(logic [7:0] b, int k);
    logic [7:0] s;
    s = b >> (k - 1);
    if (k == 0) return 1'b0;
    if (k <= 8) return s[0];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction
  // a frame owning edges q..q+len-1 appears on the registered line one edge later
  function automatic logic m_tx(int u, int tt);
    logic r = 1'b1;
    foreach (fq[i])
      if (fq[i].u == u && tt - 1 >= fq[i].q && tt - 1 < fq[i].q + NB * cpb(u))
        r = exp_bit(fq[i].b, (tt - 1 - fq[i].q) / cpb(u));
    return r;
  endfunction
  // a byte accepted at edge a but started later at q is held over edges a..q-1
  function automatic logic m_ready(int u, int tt);
    logic r = 1'b1;
    foreach (fq[i])
      if (fq[i].u == u && fq[i].q > fq[i].a && fq[i].a <= tt && tt < fq[i].q) r = 1'b0;
    return r;
  endfunction
  function automatic logic m_busy(int u, int tt);
    logic r = 1'b0;
    foreach (fq[i])
      if (fq[i].u == u && fq[i].a <= tt && tt < fq[i].q + NB * cpb(u)) r = 1'b1;
    return r;
  endfunction

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask
  task automatic chkn(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic decode(input int u);
    int k, idx;
    if (!dec_on[u]) begin
      if (tx_w[u] == 1'b0) begin
        dec_on[u] = 1'b1;
        dec_c[u] = 0;
      end
    end else begin
      dec_c[u]++;
      if (dec_c[u] % cpb(u) == 0) begin
        k = dec_c[u] / cpb(u);
        if (k >= 1 && k <= 8) dec_b[u] = {tx_w[u], dec_b[u][7:1]};
        else if (k == NB - 1) begin
          dec_on[u] = 1'b0;
          chk1($sformatf("stop bit dut%0d t=%0d", u, t), tx_w[u], 1'b1);
          idx = -1;
          foreach (sq[i]) if (idx < 0 && sq[i].u == u) idx = i;
          if (idx < 0) chkn($sformatf("unexpected frame dut%0d byte=%0h t=%0d", u, dec_b[u], t), 1, 0);
          else begin
            chkn($sformatf("decoded byte dut%0d t=%0d", u, t), int'(dec_b[u]), int'(sq[idx].b));
            sq.delete(idx);
          end
        end else chk1($sformatf("parity bit dut%0d t=%0d", u, t), tx_w[u], ^dec_b[u]);
      end
    end
  endtask
  // one clock: decide acceptance from the model, advance, then compare every output
  task automatic step(input logic r);
    int q;
    rst = r;
    for (int u = 0; u < 2; u++) acc_last[u] = !r && dv[u] && m_ready(u, t);
    @(posedge clk);
    t++;
    if (r) begin
      fq.delete();
      sq.delete();
      dec_on = '0;
      last_end = '{-100000, -100000};
    end else
      for (int u = 0; u < 2; u++)
        if (acc_last[u]) begin
          q = t > last_end[u] ? t : last_end[u];
          fq.push_back('{u, t, q, din[u]});
          sq.push_back('{u, din[u]});
          last_end[u] = q + NB * cpb(u);
        end
    while (fq.size() > 0 && fq[0].q + NB * cpb(fq[0].u) + 2 < t) void'(fq.pop_front());
    #1;
    for (int u = 0; u < 2; u++) begin
      chk1($sformatf("tx dut%0d t=%0d", u, t), tx_w[u], m_tx(u, t));
      chk1($sformatf("ready dut%0d t=%0d", u, t), rdy_w[u], m_ready(u, t));
      chk1($sformatf("busy dut%0d t=%0d", u, t), bsy_w[u], m_busy(u, t));
      decode(u);
    end
  endtask
  task automatic send(input int u, input logic [7:0] b, output int at);
    dv[u] = 1'b1;
    din[u] = b;
    at = -1;
    for (int n = 0; n < 400 && at < 0; n++) begin
      step(1'b0);
      if (acc_last[u]) at = t;
    end
    dv[u] = 1'b0;
    if (at < 0) chkn($sformatf("accept timeout dut%0d byte=%0h", u, b), 0, 1);
  endtask

  initial begin
    vec_t tv[12];
    logic [11:0] txp;
    int a1, a2, a3, cnt;
    din[0] = '0;
    din[1] = '0;
    last_end = '{-100000, -100000};
    step(1'b1);
    step(1'b1);
    for (int u = 0; u < 2; u++) begin
      chk1($sformatf("reset tx dut%0d", u), tx_w[u], 1'b1);
      chk1($sformatf("reset ready dut%0d", u), rdy_w[u], 1'b1);
      chk1($sformatf("reset busy dut%0d", u), bsy_w[u], 1'b0);
    end
`ifndef UART_TX_PARITY_EN
    txp = 12'b1110_1001_0101;
    for (int i = 0; i < 12; i++) tv[i] = '{i == 0, 8'hA5, txp[i], 1'b1, i < 10};
    for (int i = 0; i < 12; i++) begin
      dv[0] = tv[i].dv;
      din[0] = tv[i].d;
      step(1'b0);
      chk1($sformatf("A5 row%0d tx", i), tx_w[0], tv[i].tx);
      chk1($sformatf("A5 row%0d ready", i), rdy_w[0], tv[i].rdy);
      chk1($sformatf("A5 row%0d busy", i), bsy_w[0], tv[i].bsy);
    end
`endif
    send(1, 8'h00, a1);
    send(1, 8'hFF, a2);
    chkn("b2b second accept gap", a2 - a1, 1);
    chk1("b2b ready after hold", rdy_w[1], 1'b0);
    cnt = 2;
    for (int n = 0; n < 300 && bsy_w[1]; n++) begin
      step(1'b0);
      cnt += int'(bsy_w[1]);
    end
    chkn("b2b busy cycles", cnt, 2 * NB * CPB1);
    send(1, 8'h11, a1);
    send(1, 8'h22, a2);
    send(1, 8'h33, a3);
    chkn("third byte stall", a3 - a1, NB * CPB1 + 1);
    repeat (3 * NB * CPB1) step(1'b0);
`ifdef UART_TX_PARITY_EN
    send(0, 8'h07, a1);
    repeat (10) step(1'b0);
    chk1("parity of 07", tx_w[0], 1'b1);
    repeat (5) step(1'b0);
    send(0, 8'h03, a1);
    repeat (10) step(1'b0);
    chk1("parity of 03", tx_w[0], 1'b0);
    repeat (5) step(1'b0);
`endif
    send(1, 8'h3C, a1);
    send(1, 8'hC3, a2);
    repeat (16) step(1'b0);
    dv[0] = 1'b1;
    din[0] = 8'h99;
    step(1'b1);
    dv[0] = 1'b0;
    chk1("mid-frame reset tx", tx_w[1], 1'b1);
    chk1("mid-frame reset ready", rdy_w[1], 1'b1);
    chk1("mid-frame reset busy", bsy_w[1], 1'b0);
    chk1("reset beats accept", bsy_w[0], 1'b0);
    send(1, 8'h5A, a1);
    repeat (NB * CPB1 + 5) step(1'b0);
    chkn("frames outstanding after 5A", sq.size(), 0);
    for (int n = 0; n < 2500; n++) begin
      for (int u = 0; u < 2; u++)
        if (!dv[u] && $urandom_range(3) == 0) begin
          dv[u] = 1'b1;
          din[u] = 8'($urandom);
        end
      step($urandom_range(399) == 0);
      for (int u = 0; u < 2; u++) if (acc_last[u]) dv[u] = 1'b0;
    end
    dv = '0;
    repeat (3 * NB * CPB1 + 5) step(1'b0);
    chkn("frames outstanding at end", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
